priority_arbiter: RTL and testbench
===================================

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter N, default 8, number of request lines; legal range 2..32.
REQ-002 Parameter W, default 3, grant index width; SHALL equal clog2(N).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  arbitration enable; 1 allows a new grant to be issued.
REQ-006 mode  input  1  0 = fixed priority, 1 = round-robin.
REQ-007 req  input  N  request vector, one bit per requester.
REQ-008 gnt_ready  input  1  downstream accepts the presented grant.
REQ-009 gnt_valid  output  1  registered grant is valid.
REQ-010 gnt_idx  output  W  binary index of the granted requester.
REQ-011 gnt_onehot  output  N  one-hot grant; bit gnt_idx set.

Function
REQ-012 All outputs SHALL be registered, with no tristate values; when gnt_valid=0, gnt_idx=0 and gnt_onehot=0.
REQ-013 The FSM SHALL have two states, IDLE and HOLD, and SHALL reset to IDLE.
REQ-014 IDLE with en=1 and |req=1: SHALL latch the winner and move to HOLD; gnt_valid=1 from the next edge, giving 1-cycle latency from req sample to grant.
REQ-015 IDLE with en=0 or req=0: SHALL stay in IDLE with gnt_valid=0.
REQ-016 In fixed mode (mode=0), the highest set index SHALL win (req[N-1] highest, req[0] lowest).
REQ-017 In round-robin mode (mode=1), the search SHALL start at ptr and descend ptr, ptr-1, ..., 0, N-1, ..., ptr+1; the first set bit wins.
REQ-018 ptr (W bits, internal) SHALL update only on accept (gnt_valid and gnt_ready) to (gnt_idx-1) mod N, in both modes.
REQ-019 In HOLD, gnt_idx, gnt_onehot and gnt_valid SHALL stay stable until accept, regardless of changes to req, en or mode.
REQ-020 In HOLD with gnt_ready=1, the block SHALL return to IDLE; gnt_valid=0 on the next cycle (one bubble), so the maximum rate is one grant per 2 cycles.
REQ-021 A requester that drops its req while in HOLD SHALL still keep the grant until accept; the grant is not withdrawn.
REQ-022 A mode change SHALL take effect at the next IDLE arbitration only.
REQ-023 Wrap-around: ptr=0 after accept of index 0 yields ptr=N-1, and the search wraps modulo N.
REQ-024 gnt_ready while gnt_valid=0 SHALL be ignored.

Reset
REQ-025 rst_n=0 sampled at a rising edge SHALL set state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0 and ptr=N-1; the first round-robin grant then matches a fixed-priority grant.
REQ-026 Reset asserted in HOLD SHALL discard the grant; gnt_valid=0 after that edge, with no accept and no ptr update.
REQ-027 While rst_n=0, req, en and gnt_ready SHALL have no effect.

Verification (N=8)
REQ-028 Reset: rst_n=0 for 2 cycles with req=8'hFF, en=1 -> gnt_valid=0, gnt_idx=0, gnt_onehot=8'h00 throughout; first round-robin grant after release = 7.
REQ-029 Fixed mode: req=8'b1010_0100, en=1, gnt_ready=1 -> one cycle later gnt_valid=1, gnt_idx=7, gnt_onehot=8'h80; next cycle gnt_valid=0.
REQ-030 Backpressure: grant idx 7 presented, gnt_ready=0 for 3 cycles while req changes to 8'h01 -> gnt_idx stays 7 and gnt_onehot stays 8'h80 until gnt_ready=1; then the next grant is idx 0.
REQ-031 Round-robin fairness: mode=1, req=8'hFF constant, gnt_ready=1 -> grant sequence 7,6,5,4,3,2,1,0,7, one grant every 2 cycles.
REQ-032 Round-robin wrap: mode=1, req=8'h81 -> grants alternate 7,0,7,0; fixed mode with the same req -> 7 every time.
REQ-033 Enable and mid-operation reset: en=0 with req=8'h10 -> gnt_valid stays 0; set en=1 -> idx 4 granted; rst_n=0 in HOLD -> gnt_valid=0 at the next edge and ptr=7.

Source files
------------

// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between requesters and the priority arbiter.
// The master side drives requests and accepts grants; the slave side is the arbiter.
interface priority_arbiter_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic         en;
    logic         mode;
    logic [N-1:0] req;
    logic         gnt_ready;
    logic         gnt_valid;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt_onehot;

    modport master (
        output en, mode, req, gnt_ready,
        input  gnt_valid, gnt_idx, gnt_onehot
    );

    modport slave (
        input  en, mode, req, gnt_ready,
        output gnt_valid, gnt_idx, gnt_onehot
    );
endinterface

// File: rtl/priority_arbiter.sv
// Fixed-priority / round-robin arbiter with a registered, held grant.
// A grant is held until accepted, followed by one idle bubble cycle.
module priority_arbiter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    priority_arbiter_if.slave     bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] ptr, ptr_nxt;
    logic         valid_nxt;
    logic [W-1:0] idx_nxt;
    logic [N-1:0] onehot_nxt;
    logic [W-1:0] search_start;
    logic [W-1:0] winner;

    // Descending circular search from start; the first set request wins.
    function automatic logic [W-1:0] pick_winner(input logic [N-1:0] r,
                                                 input logic [W-1:0] start);
        logic [W-1:0] win;
        logic [W-1:0] kk;
        logic         found;
        int           k;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(start) - i;
            if (k < 0) k = k + N;
            kk = W'(k);
            if (!found && r[kk]) begin
                found = 1'b1;
                win   = kk;
            end
        end
        return win;
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [W-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Fixed priority is a circular search that always starts at the top index.
    assign search_start = bus.mode ? ptr : W'(N - 1);
    assign winner       = pick_winner(bus.req, search_start);

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        valid_nxt  = bus.gnt_valid;
        idx_nxt    = bus.gnt_idx;
        onehot_nxt = bus.gnt_onehot;
        case (state)
            IDLE: begin
                if (bus.en && (|bus.req)) begin
                    state_nxt  = HOLD;
                    valid_nxt  = 1'b1;
                    idx_nxt    = winner;
                    onehot_nxt = to_onehot(winner);
                end else begin
                    valid_nxt  = 1'b0;
                    idx_nxt    = '0;
                    onehot_nxt = '0;
                end
            end
            HOLD: begin
                if (bus.gnt_ready) begin
                    state_nxt  = IDLE;
                    valid_nxt  = 1'b0;
                    idx_nxt    = '0;
                    onehot_nxt = '0;
                    ptr_nxt    = (bus.gnt_idx == '0) ? W'(N - 1) : bus.gnt_idx - 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                valid_nxt  = 1'b0;
                idx_nxt    = '0;
                onehot_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= W'(N - 1);
            bus.gnt_valid  <= 1'b0;
            bus.gnt_idx    <= '0;
            bus.gnt_onehot <= '0;
        end else begin
            state          <= state_nxt;
            ptr            <= ptr_nxt;
            bus.gnt_valid  <= valid_nxt;
            bus.gnt_idx    <= idx_nxt;
            bus.gnt_onehot <= onehot_nxt;
        end
    end
endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter (N=8): directed scenarios, with expected grant
// indices queued at stimulus time and compared when each grant is accepted.
module tb_priority_arbiter;
    localparam int N = 8;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] sb[$];

    priority_arbiter_if #(.N(N), .W(W)) bus ();

    priority_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        bus.req = '0;
        rst_n   = 1'b0;
        step();
        step();
        rst_n   = 1'b1;
    endtask

    // Scoreboard: every accepted grant must match the next queued index.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && bus.gnt_valid && bus.gnt_ready) begin
            if (sb.size() == 0) begin
                check_val("sb_unexpected_grant", {29'd0, bus.gnt_idx}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check_val("sb_idx", {29'd0, bus.gnt_idx}, e);
                check_val("sb_onehot", {24'd0, bus.gnt_onehot}, 32'd1 << e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset holds outputs low even with requests and enable active.
        bus.req = 8'hFF; bus.en = 1'b1; bus.mode = 1'b1; bus.gnt_ready = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check_val("rst_valid", {31'd0, bus.gnt_valid}, 32'd0);
            check_val("rst_idx", {29'd0, bus.gnt_idx}, 32'd0);
            check_val("rst_onehot", {24'd0, bus.gnt_onehot}, 32'd0);
        end
        rst_n = 1'b1;
        sb.push_back(7);
        step();
        check_val("rst_first_rr_valid", {31'd0, bus.gnt_valid}, 32'd1);
        check_val("rst_first_rr_idx", {29'd0, bus.gnt_idx}, 32'd7);
        bus.req = '0;
        step();
        check_val("rst_first_bubble", {31'd0, bus.gnt_valid}, 32'd0);

        // Fixed priority: highest set index wins, then one bubble.
        bus.mode = 1'b0; bus.req = 8'b1010_0100;
        sb.push_back(7);
        step();
        check_val("fix_valid", {31'd0, bus.gnt_valid}, 32'd1);
        check_val("fix_idx", {29'd0, bus.gnt_idx}, 32'd7);
        check_val("fix_onehot", {24'd0, bus.gnt_onehot}, 32'h80);
        bus.req = '0;
        step();
        check_val("fix_bubble", {31'd0, bus.gnt_valid}, 32'd0);

        // Backpressure: grant is held while req changes underneath it.
        bus.req = 8'b1010_0100; bus.gnt_ready = 1'b0;
        sb.push_back(7);
        step();
        check_val("bp_valid", {31'd0, bus.gnt_valid}, 32'd1);
        bus.req = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("bp_hold_valid", {31'd0, bus.gnt_valid}, 32'd1);
            check_val("bp_hold_idx", {29'd0, bus.gnt_idx}, 32'd7);
            check_val("bp_hold_onehot", {24'd0, bus.gnt_onehot}, 32'h80);
        end
        bus.gnt_ready = 1'b1;
        sb.push_back(0);
        step();
        check_val("bp_bubble", {31'd0, bus.gnt_valid}, 32'd0);
        step();
        check_val("bp_next_idx", {29'd0, bus.gnt_idx}, 32'd0);
        check_val("bp_next_onehot", {24'd0, bus.gnt_onehot}, 32'h01);
        bus.req = '0;
        step();
        check_val("bp_end_bubble", {31'd0, bus.gnt_valid}, 32'd0);

        // Round-robin fairness with all requesters active.
        reset_dut();
        bus.mode = 1'b1; bus.req = 8'hFF; bus.gnt_ready = 1'b1;
        for (int i = 7; i >= 0; i--) sb.push_back(i);
        sb.push_back(7);
        for (int i = 0; i < 9; i++) begin
            step();
            check_val("rr_valid", {31'd0, bus.gnt_valid}, 32'd1);
            if (i == 8) bus.req = '0;
            step();
            check_val("rr_bubble", {31'd0, bus.gnt_valid}, 32'd0);
        end

        // Round-robin wrap between the two extreme requesters.
        reset_dut();
        bus.mode = 1'b1; bus.req = 8'h81;
        sb.push_back(7); sb.push_back(0); sb.push_back(7); sb.push_back(0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("wrap_valid", {31'd0, bus.gnt_valid}, 32'd1);
            if (i == 3) bus.req = '0;
            step();
        end
        // Same requests in fixed mode always favour index 7.
        bus.mode = 1'b0; bus.req = 8'h81;
        sb.push_back(7); sb.push_back(7); sb.push_back(7);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("wrap_fix_valid", {31'd0, bus.gnt_valid}, 32'd1);
            if (i == 2) bus.req = '0;
            step();
        end

        // Enable gating, then reset while a grant is held.
        bus.en = 1'b0; bus.req = 8'h10; bus.gnt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("en_off_valid", {31'd0, bus.gnt_valid}, 32'd0);
        end
        bus.en = 1'b1;
        step();
        check_val("en_on_valid", {31'd0, bus.gnt_valid}, 32'd1);
        check_val("en_on_idx", {29'd0, bus.gnt_idx}, 32'd4);
        check_val("en_on_onehot", {24'd0, bus.gnt_onehot}, 32'h10);
        rst_n = 1'b0;
        step();
        check_val("hold_rst_valid", {31'd0, bus.gnt_valid}, 32'd0);
        check_val("hold_rst_idx", {29'd0, bus.gnt_idx}, 32'd0);
        check_val("hold_rst_onehot", {24'd0, bus.gnt_onehot}, 32'd0);
        // ptr was 6 before the reset; only a restored ptr of 7 grants 7 here.
        rst_n = 1'b1; bus.mode = 1'b1; bus.req = 8'hFF; bus.gnt_ready = 1'b1;
        sb.push_back(7);
        step();
        check_val("ptr_after_rst_idx", {29'd0, bus.gnt_idx}, 32'd7);
        bus.req = '0;
        step();
        check_val("final_bubble", {31'd0, bus.gnt_valid}, 32'd0);
        step();

        check_val("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
